// File: rtl/fft_load_ctrl.sv
// Frame loader for an FFT register array: streams N samples into the array with
// optional bit-reversed addressing, then fires the FFT stage and waits for it to finish.
module fft_load_ctrl #(
    parameter int unsigned N      = 16,
    parameter int unsigned MSB    = 16,
    parameter int unsigned BITREV = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MSB-1:0]       in_data,
    output logic                 we,
    output logic [$clog2(N)-1:0] addr,
    output logic [MSB-1:0]       wdata,
    output logic                 start,
    input  logic                 fft_done,
    output logic                 busy,
    output logic [7:0]           frame_cnt,
    output logic                 err
);

    localparam int unsigned AW = $clog2(N);
    localparam logic [AW-1:0] LastCnt = AW'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFire,
        StWait
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [MSB-1:0]  wdata_q, wdata_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    logic            err_q, err_d;
    logic            accept;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int i = 0; i < int'(AW); i++) begin
            r[AW-1-i] = v[i];
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_cnt_d = frame_cnt_q;
        in_ready    = (state_q == StLoad);
        accept      = in_valid & in_ready;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end
            end
            StLoad: begin
                // enable is deliberately ignored here: a started frame always completes.
                if (accept) begin
                    if (cnt_q == LastCnt) begin
                        cnt_d   = '0;
                        state_d = StFire;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StFire: begin
                state_d = StWait;
            end
            StWait: begin
                if (fft_done) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    cnt_d       = '0;
                    state_d     = enable ? StLoad : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Write port is registered, so the last write lands in the FIRE cycle alongside start.
    always_comb begin
        we_d    = accept;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            addr_d  = (BITREV != 0) ? bitrev(cnt_q) : cnt_q;
            wdata_d = in_data;
        end
    end

    // fft_done outside WAIT is a protocol violation; the flag is sticky until reset.
    always_comb begin
        err_d = err_q | (fft_done & (state_q != StWait));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            frame_cnt_q <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
        end
    end

    assign we        = we_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign start     = (state_q == StFire);
    assign busy      = (state_q != StIdle);
    assign frame_cnt = frame_cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fft_load_ctrl.sv
// Randomized scoreboard bench: one bit-reversed and one natural-order controller share
// stimulus; a protocol-level model predicts writes, status outputs and frame counts.
module tb_fft_load_ctrl;

    localparam int unsigned N   = 16;
    localparam int unsigned MSB = 16;
    localparam int unsigned AW  = $clog2(N);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enable = 1'b0;
    logic           in_valid = 1'b0;
    logic [MSB-1:0] in_data = '0;
    logic           fft_done = 1'b0;

    logic           in_ready1, we1, start1, busy1, err1;
    logic [AW-1:0]  addr1;
    logic [MSB-1:0] wdata1;
    logic [7:0]     frame_cnt1;
    logic           in_ready0, we0, start0, busy0, err0;
    logic [AW-1:0]  addr0;
    logic [MSB-1:0] wdata0;
    logic [7:0]     frame_cnt0;

    always #5 clk = ~clk;

    fft_load_ctrl #(.N(N), .MSB(MSB), .BITREV(1)) dut_rev (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .we(we1), .addr(addr1), .wdata(wdata1), .start(start1),
        .fft_done(fft_done), .busy(busy1), .frame_cnt(frame_cnt1), .err(err1)
    );

    fft_load_ctrl #(.N(N), .MSB(MSB), .BITREV(0)) dut_nat (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .we(we0), .addr(addr0), .wdata(wdata0), .start(start0),
        .fft_done(fft_done), .busy(busy0), .frame_cnt(frame_cnt0), .err(err0)
    );

    typedef struct {
        int unsigned    idx;
        logic [MSB-1:0] data;
        bit             last;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;
    int  n_cmp = 0;
    int  n_err = 0;

    // Protocol-level model: what the frame loader should be doing right now.
    bit          m_loading, m_fire, m_waiting, m_err;
    int unsigned m_cnt;
    logic [7:0]  m_frames;

    function automatic int unsigned rev(input int unsigned v);
        int unsigned r = 0;
        for (int i = 0; i < int'(AW); i++) r = r * 2 + ((v >> i) & 1);
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (we1 || we0)) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got we=%0b/%0b, expected none at %0t",
                         we1, we0, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("we_rev", we1, 1);
                chk("we_nat", we0, 1);
                chk("addr_rev", addr1, rev(mon_e.idx));
                chk("addr_nat", addr0, mon_e.idx);
                chk("wdata_rev", wdata1, mon_e.data);
                chk("wdata_nat", wdata0, mon_e.data);
                chk("start_with_last", start1, mon_e.last);
                chk("start_with_last_nat", start0, mon_e.last);
            end
        end
    end

    task automatic model_clear();
        m_loading = 0; m_fire = 0; m_waiting = 0; m_err = 0; m_cnt = 0; m_frames = 8'd0;
    endtask

    // Call just after a rising edge; checks status, drives inputs, advances the model.
    task automatic cycle(input bit en, input bit v, input logic [MSB-1:0] d, input bit done);
        bit nl, nf, nw;
        @(negedge clk);
        chk("in_ready_rev", in_ready1, m_loading);
        chk("in_ready_nat", in_ready0, m_loading);
        chk("busy", busy1, m_loading | m_fire | m_waiting);
        chk("start", start1, m_fire);
        chk("frame_cnt_rev", frame_cnt1, m_frames);
        chk("frame_cnt_nat", frame_cnt0, m_frames);
        chk("err_rev", err1, m_err);
        chk("err_nat", err0, m_err);
        enable = en; in_valid = v; in_data = d; fft_done = done;
        nl = m_loading; nf = 0; nw = m_waiting;
        if (done && !m_waiting) m_err = 1;
        if (m_loading) begin
            if (v) begin
                sb.push_back('{idx: m_cnt, data: d, last: (m_cnt == N - 1)});
                if (m_cnt == N - 1) begin
                    nl = 0; nf = 1; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end else if (m_fire) begin
            nw = 1;
        end else if (m_waiting) begin
            if (done) begin
                m_frames = m_frames + 8'd1;
                nw = 0; nl = en; m_cnt = 0;
            end
        end else if (en) begin
            nl = 1; m_cnt = 0;
        end
        m_loading = nl; m_fire = nf; m_waiting = nw;
        @(posedge clk);
    endtask

    // Asynchronous reset applied between edges; outputs must clear without a clock.
    task automatic do_reset();
        #2;
        rst = 1; enable = 0; in_valid = 0; fft_done = 0;
        #1;
        chk("rst_we", {we1, we0}, 0);
        chk("rst_addr", {addr1, addr0}, 0);
        chk("rst_wdata", {wdata1, wdata0}, 0);
        chk("rst_start", {start1, start0}, 0);
        chk("rst_in_ready", {in_ready1, in_ready0}, 0);
        chk("rst_busy", {busy1, busy0}, 0);
        chk("rst_frame_cnt", {frame_cnt1, frame_cnt0}, 0);
        chk("rst_err", {err1, err0}, 0);
        sb.delete();
        model_clear();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
    endtask

    // vmode: 0 continuous with data=index, 1 toggling valid, 2 random valid.
    task automatic run_frame(input int vmode, input int unsigned drop_at, input int wait_n,
                             input bit end_en, input bit stray_done);
        bit tog = 1;
        int guard = 0;
        bit en, v, dn;
        logic [MSB-1:0] d;
        while (!m_fire) begin
            en = m_loading ? (m_cnt < drop_at) : 1'b1;
            v  = (vmode == 0) ? 1'b1 : (vmode == 1) ? tog : 1'($urandom_range(0, 1));
            d  = (vmode == 0) ? MSB'(m_cnt) : MSB'($urandom);
            dn = stray_done && m_loading && ($urandom_range(0, 5) == 0);
            cycle(en, v, d, dn);
            tog = ~tog;
            guard++;
            if (guard > 400) begin
                chk("frame_bound", guard, 400);
                break;
            end
        end
        for (int i = 0; i < wait_n; i++) cycle(end_en, 1'($urandom_range(0, 1)), MSB'($urandom), 0);
        cycle(end_en, 1'b0, '0, 1'b1);
    endtask

    initial begin
        model_clear();
        @(posedge clk);
        do_reset();

        run_frame(0, N, 5, 1'b1, 1'b0);
        run_frame(1, N, 5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, MSB'($urandom), 1'b0);
        run_frame(2, 7, 2, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, MSB'($urandom), 1'b0);

        for (int f = 0; f < 256; f++) run_frame(2, N, $urandom_range(1, 4), 1'b1, 1'b0);

        run_frame(2, N, 3, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);

        // Partial frame then reset: no start may appear for the discarded samples.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, MSB'($urandom), 1'b0);
        do_reset();
        run_frame(0, N, 1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fft_load_ctrl.md
FFT_LOAD_CTRL -- requirements
Module: fft_load_ctrl

Interface
REQ-001 SHALL have parameter N, default 16, number of FFT points and register slots (power of two, >=4).
REQ-002 SHALL have parameter MSB, default 16, sample word width.
REQ-003 SHALL have parameter BITREV, default 1, 1 = bit-reversed write addressing, 0 = natural order.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port enable  input  1  permits starting a new frame load.
REQ-007 SHALL have port in_valid  input  1  upstream sample valid.
REQ-008 SHALL have port in_ready  output  1  controller accepts sample this cycle.
REQ-009 SHALL have port in_data  input  MSB  upstream sample.
REQ-010 SHALL have port we  output  1  register-array write enable.
REQ-011 SHALL have port addr  output  $clog2(N)  register-array write address.
REQ-012 SHALL have port wdata  output  MSB  register-array write data.
REQ-013 SHALL have port start  output  1  one-cycle pulse: frame complete, FFT stage may run.
REQ-014 SHALL have port fft_done  input  1  FFT stage finished consuming frame.
REQ-015 SHALL have port busy  output  1  high in LOAD, FIRE, WAIT.
REQ-016 SHALL have port frame_cnt  output  8  completed frames, wraps 255->0.
REQ-017 SHALL have port err  output  1  sticky protocol error flag.

Function
REQ-018 SHALL implement states IDLE, LOAD, FIRE, WAIT.
REQ-019 IDLE: in_ready=0, busy=0; SHALL go to LOAD on enable=1, sample counter cnt=0.
REQ-020 LOAD: in_ready=1 combinationally (function of state only); accept = in_valid & in_ready.
REQ-021 On accept SHALL register we=1, wdata=in_data, addr=bitrev(cnt) if BITREV=1 else cnt, visible the cycle after accept; we=0 in all other cycles.
REQ-022 On accept SHALL increment cnt; accept with cnt=N-1 SHALL set cnt=0 and go to FIRE.
REQ-023 in_valid=0 in LOAD SHALL hold cnt and state; no timeout.
REQ-024 enable deasserted during LOAD SHALL NOT abort; frame completes normally.
REQ-025 FIRE: start=1 for exactly one cycle, in_ready=0; next state WAIT unconditionally. start coincides with the cycle carrying the last write (we=1, addr for cnt=N-1).
REQ-026 WAIT: in_ready=0; on fft_done=1 SHALL increment frame_cnt and go to LOAD if enable=1, else IDLE.
REQ-027 fft_done=1 in IDLE, LOAD or FIRE SHALL set err=1 and otherwise be ignored; err cleared only by reset.
REQ-028 bitrev(cnt) SHALL reverse all $clog2(N) bits of cnt (N=16: 1->8, 3->12, 15->15).
REQ-029 Throughput: back-to-back in_valid SHALL load N samples in N cycles; turnaround LOAD->LOAD adds FIRE plus >=1 WAIT cycle.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, cnt=0, we=0, addr=0, wdata=0, start=0, in_ready=0, busy=0, frame_cnt=0, err=0.
REQ-031 Reset mid-LOAD SHALL discard the partial frame; no start is issued for it.
REQ-032 After rst release with enable=1, the first rising edge SHALL move IDLE->LOAD.

Verification
REQ-033 N=16, BITREV=1, enable=1, continuous in_valid, in_data=0..15 -> we on 16 consecutive cycles, addr sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with matching wdata, single start pulse with last write, in_ready=0 afterwards.
REQ-034 BITREV=0, in_valid toggling 1/0 -> addr 0..15 in order, only on accept cycles, 32 cycles to start.
REQ-035 Frame loaded, fft_done pulsed 5 cycles after start with enable=1 -> frame_cnt 0->1, in_ready=1 next cycle; repeat 256 frames -> frame_cnt=0.
REQ-036 enable dropped after 7 accepts -> remaining 9 accepted, start issued, after fft_done state IDLE, in_ready=0, busy=0.
REQ-037 fft_done pulsed in LOAD -> err=1, cnt and frame_cnt unchanged; err stays 1 until rst.
REQ-038 rst asserted after 10 accepts -> all outputs zero asynchronously; after release 16 new samples give full frame starting at addr 0, exactly one start.
